// File: rtl/input_sync_filter.sv
// Per-channel synchronizer and glitch filter: output follows input SYNC_STAGES+FILTER_CYCLES edges later, with no backpressure.
// Define INPUT_SYNC_FILTER_EDGE_EN to build the registered rise/fall pulses; otherwise they are tied low.
module input_sync_filter #(
  parameter int               WIDTH         = 1,
  parameter int               SYNC_STAGES   = 2,
  parameter int               FILTER_CYCLES = 2,
  parameter bit               FAST_RELEASE  = 1'b0,
  parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] user_in,
  output logic [WIDTH-1:0] user_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  localparam int            CW       = $clog2(FILTER_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync;
  logic [WIDTH-1:0]                  s;
  logic [WIDTH-1:0]                  out_d;
  logic [CW-1:0]                     cnt_q [WIDTH];
  logic [CW-1:0]                     cnt_d [WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync <= {SYNC_STAGES{RESET_VALUE}};
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], user_in};
    end
  end

  assign s = sync[SYNC_STAGES-1];

  // A sample matching the current output always clears the counter, so a
  // pulse shorter than FILTER_CYCLES leaves no trace.
  always_comb begin
    out_d = user_out;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (s[i] != user_out[i]) begin
        if (FAST_RELEASE && !s[i]) begin
          out_d[i] = 1'b0;
        end else if (cnt_q[i] == CNT_LAST) begin
          out_d[i] = s[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      user_out <= RESET_VALUE;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      user_out <= out_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

`ifdef INPUT_SYNC_FILTER_EDGE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rise <= '0;
      fall <= '0;
    end else begin
      rise <= out_d & ~user_out;
      fall <= ~out_d & user_out;
    end
  end
`else
  assign rise = '0;
  assign fall = '0;
`endif

endmodule

// File: tb/tb_input_sync_filter.sv
// Directed bench: four filter configurations driven independently from one clock.
module tb_input_sync_filter;

`ifdef INPUT_SYNC_FILTER_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif
  localparam logic [3:0] EM = {4{EDGE_EN}};

  logic       clk;
  logic       rst0, rst1, rst2, rst3;
  logic [3:0] in0, in1, in2, in3;
  logic [3:0] out0, out1, out2, out3;
  logic [3:0] r0, r1, r2, r3;
  logic [3:0] f0, f1, f2, f3;
  int         total;
  int         bad;

  input_sync_filter #(.WIDTH(4)) d0 (
    .clk(clk), .reset(rst0), .user_in(in0), .user_out(out0), .rise(r0), .fall(f0));
  input_sync_filter #(.WIDTH(4), .FILTER_CYCLES(3)) d1 (
    .clk(clk), .reset(rst1), .user_in(in1), .user_out(out1), .rise(r1), .fall(f1));
  input_sync_filter #(.WIDTH(4), .FAST_RELEASE(1'b1)) d2 (
    .clk(clk), .reset(rst2), .user_in(in2), .user_out(out2), .rise(r2), .fall(f2));
  input_sync_filter #(.WIDTH(4), .RESET_VALUE(4'b1111)) d3 (
    .clk(clk), .reset(rst3), .user_in(in3), .user_out(out3), .rise(r3), .fall(f3));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0; rst3 = 1'b0;
    in0 = 4'h0; in1 = 4'h0; in2 = 4'h0; in3 = 4'hF;
    #7;
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1; rst3 = 1'b1;
    #1;
    total++; if (out0 !== 4'h0) begin bad++; $display("FAIL reset_out0: got %b want 0000", out0); end
    total++; if (out1 !== 4'h0) begin bad++; $display("FAIL reset_out1: got %b want 0000", out1); end
    total++; if (out3 !== 4'hF) begin bad++; $display("FAIL reset_out3: got %b want 1111", out3); end
    total++; if ((r0 | f0 | r3 | f3) !== 4'h0) begin bad++; $display("FAIL reset_edges: got %b want 0000", r0 | f0 | r3 | f3); end
    tick;
    tick;
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0; rst3 = 1'b0;
  endtask

  task automatic test_basic;
    logic [3:0] eo, er, ef;
    in0 = 4'b0001;
    for (int e = 1; e <= 5; e++) begin
      tick;
      eo = (e >= 4) ? 4'b0001 : 4'b0000;
      er = (e == 4) ? (EM & 4'b0001) : 4'b0000;
      total++; if (out0 !== eo) begin bad++; $display("FAIL basic_rise_out e%0d: got %b want %b", e, out0, eo); end
      total++; if (r0 !== er) begin bad++; $display("FAIL basic_rise_pulse e%0d: got %b want %b", e, r0, er); end
      total++; if (f0 !== 4'h0) begin bad++; $display("FAIL basic_rise_fall e%0d: got %b want 0000", e, f0); end
    end
    in0 = 4'b0000;
    for (int e = 1; e <= 5; e++) begin
      tick;
      eo = (e >= 4) ? 4'b0000 : 4'b0001;
      ef = (e == 4) ? (EM & 4'b0001) : 4'b0000;
      total++; if (out0 !== eo) begin bad++; $display("FAIL basic_fall_out e%0d: got %b want %b", e, out0, eo); end
      total++; if (f0 !== ef) begin bad++; $display("FAIL basic_fall_pulse e%0d: got %b want %b", e, f0, ef); end
      total++; if (r0 !== 4'h0) begin bad++; $display("FAIL basic_fall_rise e%0d: got %b want 0000", e, r0); end
    end
  endtask

  task automatic test_glitch;
    logic [3:0] eo, er, ef;
    in1 = 4'b0010;
    for (int e = 1; e <= 8; e++) begin
      tick;
      total++; if ((out1 | r1 | f1) !== 4'h0) begin bad++; $display("FAIL glitch_short e%0d: got out=%b rise=%b fall=%b want all 0000", e, out1, r1, f1); end
      if (e == 2) in1 = 4'b0000;
    end
    in1 = 4'b0010;
    for (int e = 1; e <= 8; e++) begin
      tick;
      eo = (e >= 5 && e <= 7) ? 4'b0010 : 4'b0000;
      er = (e == 5) ? (EM & 4'b0010) : 4'b0000;
      ef = (e == 8) ? (EM & 4'b0010) : 4'b0000;
      total++; if (out1 !== eo) begin bad++; $display("FAIL glitch_pass_out e%0d: got %b want %b", e, out1, eo); end
      total++; if (r1 !== er) begin bad++; $display("FAIL glitch_pass_rise e%0d: got %b want %b", e, r1, er); end
      total++; if (f1 !== ef) begin bad++; $display("FAIL glitch_pass_fall e%0d: got %b want %b", e, f1, ef); end
      if (e == 3) in1 = 4'b0000;
    end
  endtask

  task automatic test_fast_release;
    logic [3:0] eo, er, ef;
    in2 = 4'b0100;
    for (int e = 1; e <= 4; e++) begin
      tick;
      eo = (e == 4) ? 4'b0100 : 4'b0000;
      er = (e == 4) ? (EM & 4'b0100) : 4'b0000;
      total++; if (out2 !== eo) begin bad++; $display("FAIL fast_press_out e%0d: got %b want %b", e, out2, eo); end
      total++; if (r2 !== er) begin bad++; $display("FAIL fast_press_rise e%0d: got %b want %b", e, r2, er); end
    end
    in2 = 4'b0000;
    for (int e = 1; e <= 4; e++) begin
      tick;
      eo = (e >= 3) ? 4'b0000 : 4'b0100;
      ef = (e == 3) ? (EM & 4'b0100) : 4'b0000;
      total++; if (out2 !== eo) begin bad++; $display("FAIL fast_release_out e%0d: got %b want %b", e, out2, eo); end
      total++; if (f2 !== ef) begin bad++; $display("FAIL fast_release_fall e%0d: got %b want %b", e, f2, ef); end
      total++; if (r2 !== 4'h0) begin bad++; $display("FAIL fast_release_rise e%0d: got %b want 0000", e, r2); end
    end
    in2 = 4'b0100;
    for (int e = 1; e <= 4; e++) begin
      tick;
      eo = (e == 4) ? 4'b0100 : 4'b0000;
      er = (e == 4) ? (EM & 4'b0100) : 4'b0000;
      total++; if (out2 !== eo) begin bad++; $display("FAIL fast_repress_out e%0d: got %b want %b", e, out2, eo); end
      total++; if (r2 !== er) begin bad++; $display("FAIL fast_repress_rise e%0d: got %b want %b", e, r2, er); end
    end
  endtask

  task automatic test_reset_pending;
    logic [3:0] eo, er;
    in0 = 4'b0001;
    repeat (4) tick;
    total++; if (out0 !== 4'b0001) begin bad++; $display("FAIL pend_setup_out: got %b want 0001", out0); end
    in0 = 4'b0000;
    repeat (3) tick;
    #2;
    rst0 = 1'b1;
    #1;
    total++; if (out0 !== 4'b0000) begin bad++; $display("FAIL pend_async_out: got %b want 0000", out0); end
    total++; if ((r0 | f0) !== 4'h0) begin bad++; $display("FAIL pend_async_edges: got %b want 0000", r0 | f0); end
    in0 = 4'b0001;
    tick;
    total++; if (out0 !== 4'b0000) begin bad++; $display("FAIL pend_held_out: got %b want 0000", out0); end
    rst0 = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      tick;
      eo = (e >= 4) ? 4'b0001 : 4'b0000;
      er = (e == 4) ? (EM & 4'b0001) : 4'b0000;
      total++; if (out0 !== eo) begin bad++; $display("FAIL pend_restart_out e%0d: got %b want %b", e, out0, eo); end
      total++; if (r0 !== er) begin bad++; $display("FAIL pend_restart_rise e%0d: got %b want %b", e, r0, er); end
    end
  endtask

  task automatic test_reset_value;
    logic [3:0] eo, ef;
    for (int e = 1; e <= 3; e++) begin
      tick;
      total++; if (out3 !== 4'hF) begin bad++; $display("FAIL rv_hold_out e%0d: got %b want 1111", e, out3); end
      total++; if ((r3 | f3) !== 4'h0) begin bad++; $display("FAIL rv_hold_edges e%0d: got %b want 0000", e, r3 | f3); end
    end
    in3 = 4'b0111;
    for (int e = 1; e <= 5; e++) begin
      tick;
      eo = (e >= 4) ? 4'b0111 : 4'b1111;
      ef = (e == 4) ? (EM & 4'b1000) : 4'b0000;
      total++; if (out3 !== eo) begin bad++; $display("FAIL rv_drop_out e%0d: got %b want %b", e, out3, eo); end
      total++; if (f3 !== ef) begin bad++; $display("FAIL rv_drop_fall e%0d: got %b want %b", e, f3, ef); end
      total++; if (r3 !== 4'h0) begin bad++; $display("FAIL rv_drop_rise e%0d: got %b want 0000", e, r3); end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset;
    test_basic;
    test_glitch;
    test_fast_release;
    test_reset_pending;
    test_reset_value;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
